// File: rtl/ysyx_23060171_ifu_fetchq_if.sv
// Fetch-queue bus bundle: instruction-memory request/response channels and the decoded-side output.
// master = the fetch queue, slave = memory plus downstream consumer.
interface ysyx_23060171_ifu_fetchq_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic            out_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output out_valid, out_inst, out_pc, out_pc_plus4, out_fault,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  out_valid, out_inst, out_pc, out_pc_plus4, out_fault,
        output out_ready
    );
endinterface

// File: rtl/ysyx_23060171_ifu_fetchq.sv
// Instruction fetch unit with an in-order response queue, redirect flush and
// discard counting for requests still in flight when control flow changes.
module ysyx_23060171_ifu_fetchq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [2:0]      pc_src,
    input  logic            irq,
    input  logic [XLEN-1:0] pc_plus_imm,
    input  logic [XLEN-1:0] pc_plus_rs2,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    ysyx_23060171_ifu_fetchq_if.master bus
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] hold_addr_reg;
    logic            hold_reg;
    logic            resetting_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   discard_reg;
    logic [XLEN-1:0] rsp_pc_reg;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;

    logic [XLEN-1:0] inst_mem  [FQ_DEPTH];
    logic [XLEN-1:0] pc_mem    [FQ_DEPTH];
    logic [XLEN-1:0] pc4_mem   [FQ_DEPTH];
    logic            fault_mem [FQ_DEPTH];

    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   discard_next;

    // Once asserted, req_valid cannot drop: only an accepted request consumes capacity.
    assign req_valid = !resetting_reg &&
                       (({1'b0, outstanding_reg} + {1'b0, count_reg}) < DEPTH_W);
    assign req_addr  = hold_reg ? hold_addr_reg : fetch_pc_reg;
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_fire  = bus.imem_rsp_valid && !resetting_reg && (outstanding_reg != '0);
    assign rsp_drop  = rsp_fire && (redirect_valid || (discard_reg != '0));
    assign push      = rsp_fire && !rsp_drop;
    assign pop       = bus.out_valid && bus.out_ready && !redirect_valid;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = req_addr;
    assign bus.out_valid      = (count_reg != '0);
    assign bus.out_inst       = inst_mem[head_reg];
    assign bus.out_pc         = pc_mem[head_reg];
    assign bus.out_pc_plus4   = pc4_mem[head_reg];
    assign bus.out_fault      = fault_mem[head_reg];

    always_comb begin
        case (pc_src)
            3'b001:  sel_target = pc_plus_imm;
            3'b010:  sel_target = pc_plus_rs2;
            3'b011:  sel_target = mtvec;
            3'b100:  sel_target = mepc;
            default: sel_target = fetch_pc_reg;
        endcase
        target = irq ? mtvec : sel_target;
    end

    always_comb begin
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
        discard_next     = discard_reg;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            discard_next = outstanding_next;
        end else begin
            discard_next = discard_reg - CW'(rsp_drop) + CW'(req_fire && hold_reg);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            hold_addr_reg   <= RESET_PC;
            hold_reg        <= 1'b0;
            resetting_reg   <= 1'b1;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            rsp_pc_reg      <= RESET_PC;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            resetting_reg   <= 1'b0;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;

            if (redirect_valid) begin
                fetch_pc_reg <= target;
            end else if (req_fire && !hold_reg) begin
                fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
            end

            // A stalled request survives the redirect; it is discarded once accepted.
            if (redirect_valid && req_valid && !bus.imem_req_ready) begin
                hold_reg      <= 1'b1;
                hold_addr_reg <= req_addr;
            end else if (req_fire) begin
                hold_reg <= 1'b0;
            end

            if (redirect_valid) begin
                rsp_pc_reg <= target;
            end else if (push) begin
                rsp_pc_reg <= rsp_pc_reg + XLEN'(4);
            end

            if (redirect_valid) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + PW'(1);
                end
                if (pop) begin
                    head_reg <= head_reg + PW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_reg]  <= bus.imem_rsp_data;
            pc_mem[tail_reg]    <= rsp_pc_reg;
            pc4_mem[tail_reg]   <= rsp_pc_reg + XLEN'(4);
            fault_mem[tail_reg] <= bus.imem_rsp_err;
        end
    end
endmodule

// File: tb/tb_ysyx_23060171_ifu_fetchq.sv
// Randomized bench: a memory model tags requests with a fetch epoch, a scoreboard
// queue holds the instructions the consumer must see, and a monitor checks them.
module tb_ysyx_23060171_ifu_fetchq;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [2:0]  pc_src;
    logic        irq;
    logic [31:0] pc_plus_imm, pc_plus_rs2, mtvec, mepc;

    ysyx_23060171_ifu_fetchq_if #(.XLEN(XLEN)) bus ();

    ysyx_23060171_ifu_fetchq #(.XLEN(XLEN), .RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .pc_src(pc_src), .irq(irq),
        .pc_plus_imm(pc_plus_imm), .pc_plus_rs2(pc_plus_rs2), .mtvec(mtvec), .mepc(mepc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          tag;
        int          cyc;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
        int          cyc;
    } exp_t;

    mreq_t       memq[$];
    exp_t        expq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    logic [31:0] next_addr;
    logic [31:0] stale_addr;
    bit          stale_pending;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] rand_target();
        return RPC + 32'($urandom_range(0, 1023)) * 32'd4;
    endfunction

    task automatic idle_inputs();
        redirect_valid     = 1'b0;
        pc_src             = 3'd0;
        irq                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.out_ready      = 1'b0;
    endtask

    // Reset while the queue may be busy, then release with a stray response.
    task automatic do_reset(input int hold_cycles);
        @(negedge clk);
        cyc++;
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        memq.delete();
        expq.delete();
        stale_pending = 1'b0;
        next_addr     = RPC;
        epoch++;
        $display("cycle %0d reset asserted", cyc);
        repeat (hold_cycles) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        cyc++;
        rst                = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        chk("release_req_valid", 64'(bus.imem_req_valid), 64'd0);
        $display("cycle %0d reset released, stray response driven", cyc);
    endtask

    task automatic run(input int n, input int rdy_pct, input int ordy_pct,
                       input int rsp_pct, input int redir_pct, input int err_pct);
        for (int i = 0; i < n; i++) begin
            bit          exp_v, rdy, acc, do_rsp, redir, ordy, err;
            logic [31:0] data, tgt;
            logic [2:0]  src;
            logic        irq_v;
            logic [31:0] t_imm, t_rs2, t_mtvec, t_mepc;
            mreq_t       m;

            @(negedge clk);
            cyc++;
            rdy    = ($urandom_range(0, 99) < rdy_pct);
            ordy   = ($urandom_range(0, 99) < ordy_pct);
            redir  = ($urandom_range(0, 99) < redir_pct);
            err    = ($urandom_range(0, 99) < err_pct);
            data   = $urandom;
            do_rsp = (memq.size() > 0) && (memq[0].cyc < cyc) &&
                     ($urandom_range(0, 99) < rsp_pct);
            src     = 3'($urandom_range(0, 7));
            irq_v   = ($urandom_range(0, 3) == 0);
            t_imm   = rand_target();
            t_rs2   = rand_target();
            t_mtvec = rand_target();
            t_mepc  = rand_target();

            exp_v = (memq.size() + expq.size()) < DEPTH;
            chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_v));
            if (exp_v)
                chk("req_addr", 64'(bus.imem_req_addr), 64'(stale_pending ? stale_addr : next_addr));

            if (irq_v) tgt = t_mtvec;
            else begin
                case (src)
                    3'd1:    tgt = t_imm;
                    3'd2:    tgt = t_rs2;
                    3'd3:    tgt = t_mtvec;
                    3'd4:    tgt = t_mepc;
                    default: tgt = next_addr;
                endcase
            end

            if (do_rsp) begin
                m = memq.pop_front();
                if (!redir && m.tag == epoch)
                    expq.push_back('{pc: m.addr, inst: data, err: err, cyc: cyc});
            end

            acc = exp_v && rdy;
            if (acc) begin
                if (stale_pending) begin
                    memq.push_back('{addr: stale_addr, tag: -1, cyc: cyc});
                    stale_pending = 1'b0;
                end else begin
                    memq.push_back('{addr: next_addr, tag: epoch, cyc: cyc});
                    next_addr = next_addr + 32'd4;
                end
            end

            if (redir) begin
                epoch++;
                if (exp_v && !rdy && !stale_pending) begin
                    stale_pending = 1'b1;
                    stale_addr    = next_addr;
                end
                next_addr = tgt;
                $display("cycle %0d redirect src=%0d irq=%0b target=%h", cyc, src, irq_v, tgt);
            end

            bus.imem_req_ready = rdy;
            bus.imem_rsp_valid = do_rsp;
            bus.imem_rsp_data  = data;
            bus.imem_rsp_err   = err;
            bus.out_ready      = ordy;
            redirect_valid     = redir;
            pc_src             = src;
            irq                = irq_v;
            pc_plus_imm        = t_imm;
            pc_plus_rs2        = t_rs2;
            mtvec              = t_mtvec;
            mepc               = t_mepc;
        end
    endtask

    // Monitor: samples mid-cycle, compares the queue head with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst !== 1'b0) continue;
            if (expq.size() == 0 || expq[0].cyc >= cyc) begin
                chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("out_valid", 64'(bus.out_valid), 64'd1);
                if (bus.out_valid) begin
                    chk("out_pc", 64'(bus.out_pc), 64'(expq[0].pc));
                    chk("out_pc_plus4", 64'(bus.out_pc_plus4), 64'(expq[0].pc + 32'd4));
                    chk("out_inst", 64'(bus.out_inst), 64'(expq[0].inst));
                    chk("out_fault", 64'(bus.out_fault), 64'(expq[0].err));
                    if (bus.out_ready && !redirect_valid)
                        $display("cycle %0d out pc=%h inst=%h fault=%b", cyc,
                                 bus.out_pc, bus.out_inst, bus.out_fault);
                end
            end
            if (redirect_valid) expq.delete();
            else if (bus.out_valid && bus.out_ready && expq.size() > 0) void'(expq.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        pc_plus_imm = '0;
        pc_plus_rs2 = '0;
        mtvec       = '0;
        mepc        = '0;
        next_addr     = RPC;
        stale_addr    = RPC;
        stale_pending = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("init_out_valid", 64'(bus.out_valid), 64'd0);
        do_reset(1);

        run(30, 100, 100, 100, 0, 0);     // zero-wait streaming
        run(20, 100, 0, 100, 0, 0);       // consumer stalled: capacity limit
        run(30, 100, 100, 100, 0, 30);    // faults mixed into the stream
        run(600, 60, 70, 60, 5, 10);      // random traffic with redirects
        run(10, 100, 0, 100, 0, 0);       // fill the queue before reset
        do_reset(2);
        run(400, 50, 60, 50, 8, 10);
        run(20, 100, 100, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
